// File: rtl/approx_mul_pipe_pkg.sv
// Shared definitions for the approximate multiplier pipeline: quadrant indices,
// the carried mode word and a behavioural reference product.
package approx_mul_pipe_pkg;

  localparam int QLL = 0;
  localparam int QLH = 1;
  localparam int QHL = 2;
  localparam int QHH = 3;

  // {add_apx, mode[3:0]}
  typedef logic [4:0] mode_t;

  // Behavioural product for operands up to 32 bits (hw <= 16).
  function automatic logic [63:0] ref_prod(input int hw, input int trunc, input int or_bits,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input mode_t m);
    logic [63:0] hmask, keep, omask, al, ah, bl, bh, mid;
    logic [63:0] q [4];
    hmask = (64'd1 << hw) - 64'd1;
    keep  = ~((64'd1 << trunc) - 64'd1);
    omask = (64'd1 << or_bits) - 64'd1;
    al = {32'd0, a} & hmask;
    ah = ({32'd0, a} >> hw) & hmask;
    bl = {32'd0, b} & hmask;
    bh = ({32'd0, b} >> hw) & hmask;
    q[QLL] = al * bl;
    q[QLH] = al * bh;
    q[QHL] = ah * bl;
    q[QHH] = ah * bh;
    for (int i = 0; i < 4; i++)
      if (m[i]) q[i] = q[i] & keep;
    if (m[4])
      mid = (((q[QLH] >> or_bits) + (q[QHL] >> or_bits)) << or_bits)
          | ((q[QLH] | q[QHL]) & omask);
    else
      mid = q[QLH] + q[QHL];
    return (q[QHH] << (2 * hw)) + (mid << hw) + q[QLL];
  endfunction

endpackage

// File: rtl/approx_mul_pipe_quad.sv
// Combinational HW x HW quadrant multiplier; when apx is set the low TRUNC
// product bits are forced to zero.
module approx_quad_mul #(
  parameter int HW    = 4,
  parameter int TRUNC = 2
) (
  input  logic [HW-1:0]   x,
  input  logic [HW-1:0]   y,
  input  logic            apx,
  output logic [2*HW-1:0] q
);

  localparam logic [2*HW-1:0] KEEP = {(2*HW){1'b1}} << TRUNC;

  logic [2*HW-1:0] full;

  assign full = {{HW{1'b0}}, x} * {{HW{1'b0}}, y};
  assign q    = apx ? (full & KEEP) : full;

endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage elastic 2HW x 2HW multiplier: S1 operands, S2 quadrant
// sub-products, S3 recombined product. Per-transaction approximation control.
module approx_mul_pipe
  import approx_mul_pipe_pkg::*;
#(
  parameter int HW      = 4,
  parameter int TRUNC   = 2,
  parameter int OR_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*HW-1:0] a,
  input  logic [2*HW-1:0] b,
  input  logic [3:0]      mode,
  input  logic            add_apx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*HW-1:0] prod,
  output logic [4:0]      out_mode
);

  localparam int W2 = 2 * HW;
  localparam int W4 = 4 * HW;
  localparam logic [W4-1:0] OR_MASK = ~({W4{1'b1}} << OR_BITS);

  logic                rdy_en;
  logic                s1_v, s2_v, s3_v;
  logic                s1_ld, s2_ld, s3_ld;
  logic [W2-1:0]       s1_a, s1_b;
  mode_t               s1_m, s2_m, s3_m;
  logic [3:0][W2-1:0]  quad_q;
  logic [3:0][W2-1:0]  s2_q;
  logic [W4-1:0]       s3_p;
  logic [W4-1:0]       ll, lh, hl, hh, mid, prod_nx;

  // A stage loads when empty or when its occupant moves on this cycle.
  assign s3_ld    = !s3_v || out_ready;
  assign s2_ld    = !s2_v || s3_ld;
  assign s1_ld    = !s1_v || s2_ld;
  assign in_ready = rdy_en && s1_ld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_m <= '0;
    end else if (s1_ld) begin
      s1_v <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_a <= a;
        s1_b <= b;
        s1_m <= {add_apx, mode};
      end
    end
  end

  approx_quad_mul #(.HW(HW), .TRUNC(TRUNC)) u_ll (
    .x(s1_a[HW-1:0]), .y(s1_b[HW-1:0]), .apx(s1_m[QLL]), .q(quad_q[QLL]));
  approx_quad_mul #(.HW(HW), .TRUNC(TRUNC)) u_lh (
    .x(s1_a[HW-1:0]), .y(s1_b[W2-1:HW]), .apx(s1_m[QLH]), .q(quad_q[QLH]));
  approx_quad_mul #(.HW(HW), .TRUNC(TRUNC)) u_hl (
    .x(s1_a[W2-1:HW]), .y(s1_b[HW-1:0]), .apx(s1_m[QHL]), .q(quad_q[QHL]));
  approx_quad_mul #(.HW(HW), .TRUNC(TRUNC)) u_hh (
    .x(s1_a[W2-1:HW]), .y(s1_b[W2-1:HW]), .apx(s1_m[QHH]), .q(quad_q[QHH]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2_q <= '0;
      s2_m <= '0;
    end else if (s2_ld) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_q <= quad_q;
        s2_m <= s1_m;
      end
    end
  end

  // Approximate adder: OR the low OR_BITS, add the rest with no carry from below.
  always_comb begin
    ll  = W4'(s2_q[QLL]);
    lh  = W4'(s2_q[QLH]);
    hl  = W4'(s2_q[QHL]);
    hh  = W4'(s2_q[QHH]);
    mid = lh + hl;
    if (s2_m[4])
      mid = (((lh >> OR_BITS) + (hl >> OR_BITS)) << OR_BITS) | ((lh | hl) & OR_MASK);
    prod_nx = (hh << W2) + (mid << HW) + ll;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v <= 1'b0;
      s3_p <= '0;
      s3_m <= '0;
    end else if (s3_ld) begin
      s3_v <= s2_v;
      if (s2_v) begin
        s3_p <= prod_nx;
        s3_m <= s2_m;
      end
    end
  end

  assign out_valid = s3_v;
  assign prod      = s3_p;
  assign out_mode  = s3_m;

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed bench for approx_mul_pipe at HW=4, TRUNC=2, OR_BITS=2.
module tb_approx_mul_pipe;
  import approx_mul_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [3:0]  mode = '0;
  logic        add_apx = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] prod;
  logic [4:0]  out_mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  approx_mul_pipe #(.HW(4), .TRUNC(2), .OR_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .add_apx(add_apx),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .out_mode(out_mode));

  // Drives one transaction, scrambles the inputs after acceptance, returns the
  // result and the number of negedges from accept to out_valid (-1 on timeout).
  task automatic run_one(input logic [7:0] ta, input logic [7:0] tb, input logic [4:0] tm,
                         output logic [15:0] p, output logic [4:0] om, output int lat);
    int n;
    @(negedge clk);
    a = ta; b = tb; mode = tm[3:0]; add_apx = tm[4]; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    p = '0; om = '0; lat = -1;
    if (n >= 20) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        in_valid = 1'b0; a = ~ta; b = ~tb; mode = ~tm[3:0]; add_apx = ~tm[4];
      end
      lat++;
    end while (!out_valid && lat < 20);
    p = prod; om = out_mode;
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (prod !== 16'h0) begin bad++; $display("FAIL reset_prod got=%h exp=0000", prod); end
    total++; if (out_mode !== 5'h0) begin bad++; $display("FAIL reset_out_mode got=%h exp=00", out_mode); end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_single();
    logic [7:0]  va [6] = '{8'hFF, 8'hFF, 8'hFF, 8'h37, 8'h37, 8'hFF};
    logic [7:0]  vb [6] = '{8'hFF, 8'hFF, 8'hFF, 8'h5B, 8'h5B, 8'hFF};
    logic [4:0]  vm [6] = '{5'h00, 5'h0F, 5'h10, 5'h01, 5'h10, 5'h1F};
    logic [15:0] ve [6] = '{16'hFE01, 16'hFCE0, 16'hFDF1, 16'h138C, 16'h137D, 16'hFCE0};
    logic [15:0] p;
    logic [4:0]  om;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_one(va[i], vb[i], vm[i], p, om, lat);
      total++; if (lat != 3) begin bad++; $display("FAIL single_latency[%0d] got=%0d exp=3", i, lat); end
      total++; if (p !== ve[i]) begin bad++; $display("FAIL single_prod[%0d] got=%h exp=%h", i, p, ve[i]); end
      total++; if (om !== vm[i]) begin bad++; $display("FAIL single_mode[%0d] got=%h exp=%h", i, om, vm[i]); end
    end
  endtask

  task automatic test_zero();
    logic [15:0] p;
    logic [4:0]  om;
    int          lat;
    for (int i = 0; i < 32; i++) begin
      run_one((i % 2 == 1) ? 8'h00 : 8'hA5, (i % 2 == 1) ? 8'h3C : 8'h00, 5'(i), p, om, lat);
      total++; if (p !== 16'h0 || lat != 3) begin bad++; $display("FAIL zero_prod[%0d] got=%h lat=%0d exp=0000 lat=3", i, p, lat); end
      total++; if (om !== 5'(i)) begin bad++; $display("FAIL zero_mode[%0d] got=%h exp=%h", i, om, 5'(i)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [8] = '{8'h12, 8'hFF, 8'h80, 8'h0F, 8'hAB, 8'h07, 8'hC3, 8'h01};
    logic [7:0]  vb [8] = '{8'h34, 8'h01, 8'h80, 8'hF0, 8'hCD, 8'h09, 8'h5A, 8'h01};
    logic [4:0]  vm [8] = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F, 5'h0A};
    logic [15:0] ve [8];
    logic [63:0] r;
    int          oi;
    for (int i = 0; i < 8; i++) begin
      r = ref_prod(4, 2, 2, {24'd0, va[i]}, {24'd0, vb[i]}, vm[i]);
      ve[i] = r[15:0];
    end
    out_ready = 1'b1;
    oi = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (oi < 8) begin
          total++; if (prod !== ve[oi] || out_mode !== vm[oi] || c != oi + 3) begin
            bad++; $display("FAIL b2b_result[%0d] got=%h/%h cyc=%0d exp=%h/%h cyc=%0d", oi, prod, out_mode, c, ve[oi], vm[oi], oi + 3);
          end
          oi++;
        end else begin
          total++; bad++; $display("FAIL b2b_extra got=%h exp=none", prod);
        end
      end
      if (c < 8) begin
        a = va[c]; b = vb[c]; mode = vm[c][3:0]; add_apx = vm[c][4]; in_valid = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%0b exp=1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
    end
    total++; if (oi != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", oi); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  va [4] = '{8'h37, 8'hFF, 8'h12, 8'h99};
    logic [7:0]  vb [4] = '{8'h5B, 8'hFF, 8'h34, 8'h77};
    logic [4:0]  vm [4] = '{5'h01, 5'h10, 5'h00, 5'h00};
    logic [15:0] ve [3] = '{16'h138C, 16'hFDF1, 16'h03A8};
    int          acc, oi, n;
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        total++; if (out_valid !== 1'b1 || prod !== ve[0] || out_mode !== vm[0]) begin
          bad++; $display("FAIL bp_hold[%0d] got=%0b/%h/%h exp=1/%h/%h", c, out_valid, prod, out_mode, ve[0], vm[0]);
        end
      end
      a = va[acc]; b = vb[acc]; mode = vm[acc][3:0]; add_apx = vm[acc][4]; in_valid = 1'b1;
      if (in_ready) acc++;
    end
    total++; if (acc != 3) begin bad++; $display("FAIL bp_accepts got=%0d exp=3", acc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    oi = 0;
    n = 0;
    while (oi < 3 && n < 10) begin
      if (out_valid) begin
        total++; if (prod !== ve[oi]) begin bad++; $display("FAIL bp_drain[%0d] got=%h exp=%h", oi, prod, ve[oi]); end
        oi++;
      end
      @(negedge clk);
      n++;
    end
    total++; if (oi != 3) begin bad++; $display("FAIL bp_drain_count got=%0d exp=3", oi); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    logic [4:0]  om;
    int          lat, seen;
    out_ready = 1'b0;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; mode = 4'h0; add_apx = 1'b0; in_valid = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready0 got=%0b exp=1", in_ready); end
    @(negedge clk);
    a = 8'h12; b = 8'h34;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready1 got=%0b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || prod !== 16'hFE01) begin
      bad++; $display("FAIL rm_pre got=%0b/%h exp=1/fe01", out_valid, prod);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || prod !== 16'h0 || out_mode !== 5'h0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL rm_async got=%0b/%h/%h/%0b exp=0/0000/00/0", out_valid, prod, out_mode, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rm_stale got=%0d exp=0", seen); end
    run_one(8'h37, 8'h5B, 5'h01, p, om, lat);
    total++; if (p !== 16'h138C || om !== 5'h01 || lat != 3) begin
      bad++; $display("FAIL rm_after got=%h/%h lat=%0d exp=138c/01 lat=3", p, om, lat);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/approx_mul_pipe.md
Name: approx_mul_pipe

Overview:
- Parametrised, pipelined 2HW x 2HW unsigned multiplier built from four HW x HW quadrant sub-products (LL, LH, HL, HH) and a recombining adder.
- Each quadrant can be switched between exact and truncated-approximate at run time, per transaction; the adder can be switched between exact and OR-approximate.
- Valid/ready handshake on both sides, so it drops into the error-characterisation datapath and FPGA benchmarking harness of the approximate-multiplier family.

Parameters:
- HW, 4: half operand width; operands are 2*HW bits, product is 4*HW bits.
- TRUNC, 2: low bits forced to 0 in an approximate quadrant sub-product; legal range 0..2*HW.
- OR_BITS, 2: low bits of the middle-term sum computed by bitwise OR in approximate-adder mode; legal range 0..2*HW.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand transaction present
- in_ready  out  1  block accepts a transaction this cycle
- a  in  2*HW  multiplicand, unsigned
- b  in  2*HW  multiplier, unsigned
- mode  in  4  per-quadrant approx enable: bit0 LL, bit1 LH (a_lo*b_hi), bit2 HL (a_hi*b_lo), bit3 HH
- add_apx  in  1  1 = approximate middle-term adder
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- prod  out  4*HW  product
- out_mode  out  5  {add_apx, mode} of the transaction carried with prod

Behaviour:
- Reset (async assert, sync release): all stage valid flags = 0; out_valid = 0; prod = 0; out_mode = 0; in_ready = 1 one cycle after release, or immediately if that is simpler, but never 1 while rst_n = 0.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Three-stage elastic pipeline. Each stage holds a valid flag plus data. A stage loads when it is empty or its contents leave the same cycle.
  - S1: registers a, b, mode, add_apx.
  - S2: registers the four HW-bit-squared sub-products.
    - q = x*y (2*HW bits).
    - If the quadrant's mode bit = 1: q with bits [TRUNC-1:0] cleared.
  - S3: registers prod and out_mode; drives the outputs.
- Recombination:
  - Exact (add_apx = 0): prod = (HH << 2HW) + ((LH + HL) << HW) + LL, with full carries and no overflow in 4*HW bits.
  - Approximate (add_apx = 1): M = LH + HL, where M[OR_BITS-1:0] = LH[OR_BITS-1:0] | HL[OR_BITS-1:0]. The upper part of M = (LH >> OR_BITS) + (HL >> OR_BITS), placed at bit OR_BITS, with no carry in from the OR region. Then prod = (HH << 2HW) + (M << HW) + LL, exact.
- Latency: 3 cycles from input transfer to out_valid when out_ready is held at 1.
- Throughput: 1 transaction per cycle.
- in_ready = !S1.valid | S1 advances. It is combinationally dependent on out_ready through the stage chain; no bubble is inserted when the pipe is full and out_ready = 1.
- Backpressure: while out_valid & !out_ready, prod and out_mode hold stable. The pipe fills to 3 entries, then in_ready = 0.
- Ordering: results leave in acceptance order. None are dropped or duplicated.
- Simultaneous accept and emit with a full pipe: both transfers occur; occupancy is unchanged.
- Mode and add_apx are sampled only at input transfer. Changes on those inputs while a transaction is in flight do not affect it.
- Reset mid-operation: all in-flight transactions are discarded and the outputs return to their reset values.
- Widths: all arithmetic is unsigned, zero-extended to 4*HW bits before shifting.

Decomposition:
- Shared package holds:
  - the quadrant index constants QLL = 0, QLH = 1, QHL = 2, QHH = 3;
  - a typedef for the 5-bit mode word;
  - a function for the reference product model used by the bench.
- One sub-module, approx_quad_mul: combinational HW x HW multiplier with TRUNC and an enable input. It is instantiated four times in S2.

Test Plan:
- HW=4, TRUNC=2, OR_BITS=2. a=0xFF, b=0xFF, mode=0, add_apx=0 -> prod=0xFE01, out_valid exactly 3 cycles after accept.
- Same operands, mode=4'hF, add_apx=0 -> each quadrant 0xE0 -> prod=0xFCE0, out_mode=5'h0F.
- Same operands, mode=0, add_apx=1 -> M=449 -> prod=0xFDF1, out_mode=5'h10.
- Back-to-back stream of 8 random operands with in_valid=1, out_ready=1 -> one result per cycle, in order, each matching the package model. a=0 or b=0 -> prod=0 in every mode.
- Hold out_ready=0 while streaming:
  - after 3 accepts, in_ready=0 and prod stays stable;
  - then release out_ready -> all 3 results emerge in order, no loss.
- Assert rst_n=0 with 2 transactions in flight -> out_valid=0 and prod=0 immediately; after release, there is no stale output and the next accepted transaction returns the correct product.
